// File: rtl/pcr_sfp_pkg.sv
// Shared constants, FSM encoding and delay-line entry for the egress PCR amend path.
package pcr_sfp_pkg;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned UDP_HDR_LEN = 8;
    localparam int unsigned TS_PKT_LEN  = 188;
    localparam int unsigned PCR_EXT_MOD = 300;
    localparam int unsigned BYTE_IDX_W  = 11;
    localparam int unsigned TS_IDX_W    = 8;
    localparam int unsigned DELAY_LEN   = 7;
    localparam int unsigned BASE_W      = 33;
    localparam int unsigned EXT_W       = 9;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned PCR_W       = 48;

    localparam logic [7:0] TS_SYNC = 8'h47;

    // Parser state names the TS byte currently presented on the input.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_AFLEN,
        ST_AFFLAG,
        ST_PCR0,
        ST_PCR1,
        ST_PCR2,
        ST_PCR3,
        ST_PCR4,
        ST_PCR5
    } pcr_state_e;

    // One byte slot of the fixed-latency delay line.
    typedef struct packed {
        logic [7:0] data;
        logic       en;
        logic       good;
        logic       bad;
    } dl_entry_t;

endpackage

// File: rtl/pcr_time_add.sv
// Adds a 33-bit base / mod-300 extension time onto a PCR value.
module pcr_time_add
    import pcr_sfp_pkg::*;
(
    input  logic [BASE_W-1:0] base_old_i,
    input  logic [EXT_W-1:0]  ext_old_i,
    input  logic [BASE_W-1:0] base_add_i,
    input  logic [EXT_W-1:0]  ext_add_i,
    output logic [BASE_W-1:0] base_new_o,
    output logic [EXT_W-1:0]  ext_new_o,
    output logic              ext_invalid_o
);

    logic [EXT_W:0] ext_sum_c;
    logic           carry_c;

    // Extension sum with carry into the base when it reaches the modulus.
    always_comb begin
        ext_invalid_o = (ext_old_i >= EXT_W'(PCR_EXT_MOD));
        ext_sum_c     = {1'b0, ext_old_i} + {1'b0, ext_add_i};
        carry_c       = (ext_sum_c >= (EXT_W + 1)'(PCR_EXT_MOD));
        ext_new_o     = carry_c ? EXT_W'(ext_sum_c - (EXT_W + 1)'(PCR_EXT_MOD))
                                : ext_sum_c[EXT_W-1:0];
        base_new_o    = base_old_i + base_add_i + BASE_W'(carry_c);
    end

endmodule

// File: rtl/pcr_amend_back_sfp.sv
// Egress PCR amend: adds the departure time back onto every PCR in UDP/TS frames.
module pcr_amend_back_sfp
    import pcr_sfp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pcr_din,
    input  logic              pcr_din_en,
    input  logic              good_frame_in,
    input  logic              bad_frame_in,
    input  logic [BASE_W-1:0] pcr_base_cnt,
    input  logic [EXT_W-1:0]  pcr_ext_cnt,
    output logic [7:0]        pcr_dout,
    output logic              pcr_dout_en,
    output logic              good_frame_out,
    output logic              bad_frame_out,
    output logic [CNT_W-1:0]  pcr_amend_cnt,
    output logic [CNT_W-1:0]  pcr_err_cnt
);

    pcr_state_e state_q, state_d;

    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [BYTE_IDX_W-1:0] hdr_end_q, hdr_end_d;
    logic [TS_IDX_W-1:0]   ts_idx_q, ts_idx_d;
    logic [BASE_W-1:0]     base_hold_q, base_hold_d;
    logic [EXT_W-1:0]      ext_hold_q, ext_hold_d;
    logic [CNT_W-1:0]      amend_cnt_q, amend_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

    dl_entry_t [DELAY_LEN-1:0] dl_q, dl_d;

    logic                payload_c;
    logic [TS_IDX_W-1:0] ts_pos_c;
    logic                rewrite_c;
    logic [PCR_W-1:0]    pcr_word_c;
    logic [PCR_W-1:0]    pcr_new_c;
    logic [BASE_W-1:0]   base_new_c;
    logic [EXT_W-1:0]    ext_new_c;
    logic                ext_invalid_c;

    // Current byte position: payload only once this frame's IHL has been latched.
    always_comb begin
        payload_c  = pcr_din_en && (byte_idx_q > BYTE_IDX_W'(ETH_HDR_LEN))
                     && (byte_idx_q >= hdr_end_q);
        ts_pos_c   = (byte_idx_q == hdr_end_q) ? '0 : ts_idx_q;
        rewrite_c  = pcr_din_en && (state_q == ST_PCR5);
        pcr_word_c = {dl_q[4].data, dl_q[3].data, dl_q[2].data,
                      dl_q[1].data, dl_q[0].data, pcr_din};
        pcr_new_c  = {base_new_c, pcr_word_c[EXT_W+5:EXT_W], ext_new_c};
    end

    pcr_time_add u_time_add (
        .base_old_i    (pcr_word_c[PCR_W-1:PCR_W-BASE_W]),
        .ext_old_i     (pcr_word_c[EXT_W-1:0]),
        .base_add_i    (base_hold_q),
        .ext_add_i     (ext_hold_q),
        .base_new_o    (base_new_c),
        .ext_new_o     (ext_new_c),
        .ext_invalid_o (ext_invalid_c)
    );

    // Parser next state; any gap in byte valid drops back to IDLE.
    always_comb begin
        state_d = state_q;
        if (!pcr_din_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (payload_c && ts_pos_c == '0 && pcr_din == TS_SYNC) state_d = ST_HDR1;
                ST_HDR1:   state_d = ST_HDR2;
                ST_HDR2:   state_d = ST_HDR3;
                ST_HDR3:   state_d = pcr_din[5] ? ST_AFLEN : ST_IDLE;
                ST_AFLEN:  state_d = (pcr_din != 8'h00) ? ST_AFFLAG : ST_IDLE;
                ST_AFFLAG: state_d = pcr_din[4] ? ST_PCR0 : ST_IDLE;
                ST_PCR0:   state_d = ST_PCR1;
                ST_PCR1:   state_d = ST_PCR2;
                ST_PCR2:   state_d = ST_PCR3;
                ST_PCR3:   state_d = ST_PCR4;
                ST_PCR4:   state_d = ST_PCR5;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Byte/TS position tracking, departure-time capture and counters.
    always_comb begin
        byte_idx_d  = '0;
        hdr_end_d   = hdr_end_q;
        ts_idx_d    = '0;
        base_hold_d = base_hold_q;
        ext_hold_d  = ext_hold_q;
        amend_cnt_d = amend_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (pcr_din_en) begin
            byte_idx_d = (byte_idx_q == '1) ? byte_idx_q : byte_idx_q + BYTE_IDX_W'(1);
            if (byte_idx_q == BYTE_IDX_W'(ETH_HDR_LEN)) begin
                hdr_end_d = BYTE_IDX_W'(ETH_HDR_LEN + UDP_HDR_LEN)
                            + {5'd0, pcr_din[3:0], 2'b00};
            end
        end
        if (payload_c) begin
            ts_idx_d = (ts_pos_c == TS_IDX_W'(TS_PKT_LEN - 1)) ? '0
                                                               : ts_pos_c + TS_IDX_W'(1);
        end
        if (pcr_din_en && state_q == ST_PCR0) begin
            base_hold_d = pcr_base_cnt;
            ext_hold_d  = pcr_ext_cnt;
        end
        if (rewrite_c) begin
            if (ext_invalid_c) err_cnt_d   = err_cnt_q + CNT_W'(1);
            else               amend_cnt_d = amend_cnt_q + CNT_W'(1);
        end
    end

    // Delay line shift with in-place overwrite of all six PCR bytes.
    always_comb begin
        dl_d = {dl_q[DELAY_LEN-2:0], dl_entry_t'({pcr_din, pcr_din_en, good_frame_in, bad_frame_in})};
        if (rewrite_c && !ext_invalid_c) begin
            dl_d[5].data = pcr_new_c[47:40];
            dl_d[4].data = pcr_new_c[39:32];
            dl_d[3].data = pcr_new_c[31:24];
            dl_d[2].data = pcr_new_c[23:16];
            dl_d[1].data = pcr_new_c[15:8];
            dl_d[0].data = pcr_new_c[7:0];
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_idx_q  <= '0;
            hdr_end_q   <= '0;
            ts_idx_q    <= '0;
            base_hold_q <= '0;
            ext_hold_q  <= '0;
            amend_cnt_q <= '0;
            err_cnt_q   <= '0;
            dl_q        <= '0;
        end else begin
            byte_idx_q  <= byte_idx_d;
            hdr_end_q   <= hdr_end_d;
            ts_idx_q    <= ts_idx_d;
            base_hold_q <= base_hold_d;
            ext_hold_q  <= ext_hold_d;
            amend_cnt_q <= amend_cnt_d;
            err_cnt_q   <= err_cnt_d;
            dl_q        <= dl_d;
        end
    end

    assign pcr_dout       = dl_q[DELAY_LEN-1].data;
    assign pcr_dout_en    = dl_q[DELAY_LEN-1].en;
    assign good_frame_out = dl_q[DELAY_LEN-1].good;
    assign bad_frame_out  = dl_q[DELAY_LEN-1].bad;
    assign pcr_amend_cnt  = amend_cnt_q;
    assign pcr_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pcr_amend_back_sfp.sv
// Directed bench for the egress PCR amend block.
module tb_pcr_amend_back_sfp;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pcr_din;
    logic        pcr_din_en;
    logic        good_frame_in;
    logic        bad_frame_in;
    logic [32:0] pcr_base_cnt;
    logic [8:0]  pcr_ext_cnt;
    logic [7:0]  pcr_dout;
    logic        pcr_dout_en;
    logic        good_frame_out;
    logic        bad_frame_out;
    logic [15:0] pcr_amend_cnt;
    logic [15:0] pcr_err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] frm  [0:2047];
    logic [7:0] expb [0:2047];
    logic [7:0] cap  [$];
    int in_first, out_first, gin_cyc, gout_cyc, bout_cyc;

    pcr_amend_back_sfp dut (
        .clk            (clk),
        .rst            (rst),
        .pcr_din        (pcr_din),
        .pcr_din_en     (pcr_din_en),
        .good_frame_in  (good_frame_in),
        .bad_frame_in   (bad_frame_in),
        .pcr_base_cnt   (pcr_base_cnt),
        .pcr_ext_cnt    (pcr_ext_cnt),
        .pcr_dout       (pcr_dout),
        .pcr_dout_en    (pcr_dout_en),
        .good_frame_out (good_frame_out),
        .bad_frame_out  (bad_frame_out),
        .pcr_amend_cnt  (pcr_amend_cnt),
        .pcr_err_cnt    (pcr_err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output capture on the falling edge.
    always @(negedge clk) begin
        if (pcr_dout_en) begin
            cap.push_back(pcr_dout);
            if (out_first < 0) out_first = cyc;
        end
        if (good_frame_out) gout_cyc = cyc;
        if (bad_frame_out)  bout_cyc = cyc;
    end

    function automatic logic [47:0] mk_pcr(input logic [32:0] b, input logic [5:0] r,
                                           input logic [8:0] e);
        return {b, r, e};
    endfunction

    task automatic build_hdr(input logic [3:0] ihl, output int hend);
        logic [7:0] b;
        hend = 14 + 4 * int'(ihl) + 8;
        for (int i = 0; i < hend; i++) begin
            if (i < 14)       b = 8'(8'hA0 + i);
            else if (i == 14) b = {4'h4, ihl};
            else              b = 8'(i * 3);
            frm[i]  = b;
            expb[i] = b;
        end
    endtask

    // kind: 0 plain, 1 PCR, 2 AF without PCR flag, 3 zero-length AF
    task automatic put_pkt(input int s, input int kind, input logic [47:0] pin,
                           input logic [47:0] pexp);
        logic [7:0] b;
        for (int j = 0; j < 188; j++) begin
            b = 8'(j * 7 + s);
            frm[s+j] = b;
            expb[s+j] = b;
        end
        frm[s+20] = 8'h47; frm[s+21] = 8'h40; frm[s+22] = 8'h00;
        frm[s+23] = 8'h30; frm[s+24] = 8'h07; frm[s+25] = 8'h10;
        for (int j = 20; j < 26; j++) expb[s+j] = frm[s+j];
        frm[s]   = 8'h47;
        frm[s+1] = 8'h01;
        frm[s+2] = 8'h00;
        case (kind)
            0: frm[s+3] = 8'h10;
            1: begin
                frm[s+3] = 8'h30; frm[s+4] = 8'h07; frm[s+5] = 8'h10;
                for (int k = 0; k < 6; k++) begin
                    frm[s+6+k]  = pin[47-8*k -: 8];
                    expb[s+6+k] = pexp[47-8*k -: 8];
                end
            end
            2: begin frm[s+3] = 8'h30; frm[s+4] = 8'h01; frm[s+5] = 8'h00; end
            default: begin frm[s+3] = 8'h30; frm[s+4] = 8'h00; frm[s+5] = 8'h10; end
        endcase
        for (int j = 0; j < 6; j++) expb[s+j] = frm[s+j];
    endtask

    task automatic send_frame(input int n, input logic bad);
        cap.delete();
        out_first = -1;
        gout_cyc  = -1;
        bout_cyc  = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pcr_din       = frm[i];
            pcr_din_en    = 1'b1;
            good_frame_in = (i == n - 1) && !bad;
            bad_frame_in  = (i == n - 1) && bad;
            if (i == 0) in_first = cyc;
            if (i == n - 1) gin_cyc = cyc;
        end
        @(posedge clk); #1;
        pcr_din       = 8'h00;
        pcr_din_en    = 1'b0;
        good_frame_in = 1'b0;
        bad_frame_in  = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Collects differences between captured and expected bytes.
    task automatic frame_diff(input int n, output int nb, output int fb,
                              output logic [7:0] got, output logic [7:0] want);
        nb = 0; fb = -1; got = '0; want = '0;
        for (int i = 0; i < n; i++) begin
            if (i >= cap.size() || cap[i] !== expb[i]) begin
                if (fb < 0) begin
                    fb = i; want = expb[i];
                    got = (i < cap.size()) ? cap[i] : 8'h00;
                end
                nb++;
            end
        end
        if (cap.size() > n) nb += cap.size() - n;
    endtask

    task automatic test_reset();
        int he, n, nb, fb;
        logic [7:0] g, w;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pcr_dout_en !== 1'b0 || pcr_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_init: en=%b dout=%h want en=0 dout=00", pcr_dout_en, pcr_dout);
        end
        checks++;
        if (pcr_amend_cnt !== 16'd0 || pcr_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_init_cnt: amend=%0d err=%0d want 0 0", pcr_amend_cnt, pcr_err_cnt);
        end
        rst = 1'b1;
        build_hdr(4'd5, he);
        put_pkt(he, 0, '0, '0);
        put_pkt(he + 188, 0, '0, '0);
        n = he + 376;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            pcr_din = frm[i]; pcr_din_en = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0; pcr_din = frm[30];
        @(posedge clk); #1; pcr_din = frm[31];
        @(posedge clk); #1; pcr_din = frm[32];
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pcr_dout_en !== 1'b0 || pcr_dout !== 8'h00 || good_frame_out !== 1'b0
            || bad_frame_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: en=%b dout=%h good=%b bad=%b want all 0",
                     pcr_dout_en, pcr_dout, good_frame_out, bad_frame_out);
        end
        rst = 1'b1; pcr_din_en = 1'b0; pcr_din = 8'h00;
        repeat (10) @(posedge clk);
        send_frame(n, 1'b0);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL reset_frame_data: %0d bad bytes, first idx %0d got %h want %h", nb, fb, g, w);
        end
        checks++;
        if (out_first - in_first !== 7) begin
            errors++;
            $display("FAIL reset_latency: got %0d want 7", out_first - in_first);
        end
    endtask

    task automatic test_plain();
        int he, n, nb, fb;
        logic [7:0] g, w;
        int kinds [7] = '{0, 2, 3, 0, 0, 2, 3};
        pcr_base_cnt = 33'h0_0000_0500; pcr_ext_cnt = 9'd50;
        build_hdr(4'd5, he);
        for (int p = 0; p < 7; p++) put_pkt(he + 188 * p, kinds[p], '0, '0);
        n = he + 7 * 188;
        send_frame(n, 1'b0);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL plain_data: %0d bad bytes, first idx %0d got %h want %h", nb, fb, g, w);
        end
        checks++;
        if (out_first - in_first !== 7) begin
            errors++;
            $display("FAIL plain_latency: got %0d want 7", out_first - in_first);
        end
        checks++;
        if (gout_cyc - gin_cyc !== 7) begin
            errors++;
            $display("FAIL plain_good_lag: got %0d want 7", gout_cyc - gin_cyc);
        end
        checks++;
        if (pcr_amend_cnt !== 16'd0 || pcr_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL plain_cnt: amend=%0d err=%0d want 0 0", pcr_amend_cnt, pcr_err_cnt);
        end
    endtask

    task automatic test_pcr_basic();
        int he, n, nb, fb;
        logic [7:0] g, w;
        pcr_base_cnt = 33'h0_0000_0500; pcr_ext_cnt = 9'd50;
        build_hdr(4'd5, he);
        put_pkt(he, 1, mk_pcr(33'h0_0000_1000, 6'h3F, 9'd100),
                       mk_pcr(33'h0_0000_1500, 6'h3F, 9'd150));
        put_pkt(he + 188, 0, '0, '0);
        n = he + 376;
        send_frame(n, 1'b0);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL pcr_basic_data: %0d bad bytes, first idx %0d got %h want %h", nb, fb, g, w);
        end
        checks++;
        if (pcr_amend_cnt !== 16'd1 || pcr_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pcr_basic_cnt: amend=%0d err=%0d want 1 0", pcr_amend_cnt, pcr_err_cnt);
        end
    endtask

    task automatic test_carry_wrap();
        int he, n, nb, fb;
        logic [7:0] g, w;
        pcr_base_cnt = 33'h0; pcr_ext_cnt = 9'd1;
        build_hdr(4'd5, he);
        put_pkt(he, 1, mk_pcr(33'h1_FFFF_FFFF, 6'h15, 9'd299),
                       mk_pcr(33'h0_0000_0000, 6'h15, 9'd0));
        put_pkt(he + 188, 1, mk_pcr(33'h0_0000_0005, 6'h2A, 9'd298),
                             mk_pcr(33'h0_0000_0005, 6'h2A, 9'd299));
        n = he + 376;
        send_frame(n, 1'b0);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL carry_wrap_data: %0d bad bytes, first idx %0d got %h want %h", nb, fb, g, w);
        end
        checks++;
        if (pcr_amend_cnt !== 16'd3 || pcr_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL carry_wrap_cnt: amend=%0d err=%0d want 3 0", pcr_amend_cnt, pcr_err_cnt);
        end
    endtask

    task automatic test_illegal_ext();
        int he, n, nb, fb;
        logic [7:0] g, w;
        pcr_base_cnt = 33'h0_0000_0500; pcr_ext_cnt = 9'd50;
        build_hdr(4'd5, he);
        put_pkt(he, 1, mk_pcr(33'h0_0000_0123, 6'h3F, 9'h1FF),
                       mk_pcr(33'h0_0000_0123, 6'h3F, 9'h1FF));
        put_pkt(he + 188, 1, mk_pcr(33'h0_0000_0456, 6'h3F, 9'd300),
                             mk_pcr(33'h0_0000_0456, 6'h3F, 9'd300));
        put_pkt(he + 376, 1, mk_pcr(33'h0_0000_0007, 6'h3F, 9'd299),
                             mk_pcr(33'h0_0000_0508, 6'h3F, 9'd49));
        n = he + 564;
        send_frame(n, 1'b0);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL illegal_data: %0d bad bytes, first idx %0d got %h want %h", nb, fb, g, w);
        end
        checks++;
        if (pcr_amend_cnt !== 16'd4 || pcr_err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL illegal_cnt: amend=%0d err=%0d want 4 2", pcr_amend_cnt, pcr_err_cnt);
        end
    endtask

    task automatic test_en_drop();
        int he, n, nb, fb;
        logic [7:0] g, w;
        pcr_base_cnt = 33'h0_0000_0500; pcr_ext_cnt = 9'd50;
        build_hdr(4'd5, he);
        put_pkt(he, 1, mk_pcr(33'h0_0000_3000, 6'h3F, 9'd5),
                       mk_pcr(33'h0_0000_3000, 6'h3F, 9'd5));
        n = he + 8;
        send_frame(n, 1'b1);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL drop_data: %0d bad bytes, first idx %0d got %h want %h", nb, fb, g, w);
        end
        checks++;
        if (bout_cyc - gin_cyc !== 7) begin
            errors++;
            $display("FAIL drop_bad_lag: got %0d want 7", bout_cyc - gin_cyc);
        end
        checks++;
        if (pcr_amend_cnt !== 16'd4 || pcr_err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL drop_cnt: amend=%0d err=%0d want 4 2", pcr_amend_cnt, pcr_err_cnt);
        end
        build_hdr(4'd6, he);
        put_pkt(he, 1, mk_pcr(33'h0_0000_2000, 6'h3F, 9'd0),
                       mk_pcr(33'h0_0000_2500, 6'h3F, 9'd50));
        put_pkt(he + 188, 1, mk_pcr(33'h0_ABCD_0000, 6'h3F, 9'd280),
                             mk_pcr(33'h0_ABCD_0501, 6'h3F, 9'd30));
        put_pkt(he + 376, 1, mk_pcr(33'h1_0000_0000, 6'h00, 9'd10),
                             mk_pcr(33'h1_0000_0500, 6'h00, 9'd60));
        n = he + 564;
        send_frame(n, 1'b0);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0) begin
            errors++;
            $display("FAIL ihl6_data: %0d bad bytes, first idx %0d got %h want %h", nb, fb, g, w);
        end
        checks++;
        if (pcr_amend_cnt !== 16'd7 || pcr_err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL ihl6_cnt: amend=%0d err=%0d want 7 2", pcr_amend_cnt, pcr_err_cnt);
        end
        build_hdr(4'd5, he);
        frm[20] = 8'h47; frm[21] = 8'h40; frm[22] = 8'h00; frm[23] = 8'h30;
        for (int i = 20; i < 24; i++) expb[i] = frm[i];
        n = 30;
        send_frame(n, 1'b0);
        frame_diff(n, nb, fb, g, w);
        checks++;
        if (nb !== 0 || pcr_amend_cnt !== 16'd7) begin
            errors++;
            $display("FAIL short_frame: %0d bad bytes (first %0d got %h want %h) amend=%0d want 7",
                     nb, fb, g, w, pcr_amend_cnt);
        end
    endtask

    initial begin
        rst = 1'b0;
        pcr_din = 8'h00;
        pcr_din_en = 1'b0;
        good_frame_in = 1'b0;
        bad_frame_in = 1'b0;
        pcr_base_cnt = '0;
        pcr_ext_cnt = '0;
        out_first = -1;
        gout_cyc = -1;
        bout_cyc = -1;
        test_reset();
        test_plain();
        test_pcr_basic();
        test_carry_wrap();
        test_illegal_ext();
        test_en_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcr_amend_back_sfp.md
Name: pcr_amend_back_sfp

Overview:
- Egress counterpart of the ingress PCR amend stage on the 1G SFP path.
- Ingress subtracts the arrival timestamp from every PCR; this block adds the departure timestamp back, so each outgoing PCR carries the true residence delay.
- Sits just before the SFP MAC transmit path.
- Consumes byte-wide Ethernet/IPv4/UDP frames carrying MPEG-TS.
- Rewrites PCR fields in place; passes all other bytes and framing strobes through with fixed latency.

Parameters:
- ETH_HDR_LEN, 14, byte offset of the IPv4 header (version/IHL byte index).
- UDP_HDR_LEN, 8, UDP header bytes between the IP header and the TS payload.
- TS_PKT_LEN, 188, TS packet length in bytes.
- PCR_EXT_MOD, 300, modulus of the 9-bit PCR extension.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-low.
- pcr_din  in  8  frame byte.
- pcr_din_en  in  1  byte valid; high continuously for one frame, low between frames.
- good_frame_in  in  1  end-of-frame good strobe.
- bad_frame_in  in  1  end-of-frame bad strobe.
- pcr_base_cnt  in  33  departure time base, 90 kHz units.
- pcr_ext_cnt  in  9  departure time extension, 0..299 guaranteed.
- pcr_dout  out  8  amended byte.
- pcr_dout_en  out  1  delayed pcr_din_en.
- good_frame_out  out  1  delayed good_frame_in.
- bad_frame_out  out  1  delayed bad_frame_in.
- pcr_amend_cnt  out  16  count of PCRs rewritten, wraps at 65535.
- pcr_err_cnt  out  16  count of PCRs skipped because the stream extension was >= 300, wraps.

Behaviour:
- Reset (rst=0 at a clk edge):
  - all outputs 0; counters 0; FSM to IDLE; delay line cleared.
- Latency:
  - pcr_dout, pcr_dout_en, good_frame_out and bad_frame_out all lag their inputs by exactly 7 cycles, every cycle, regardless of en.
  - Implemented as a 7-stage byte/strobe delay line that shifts every cycle.
- Byte index:
  - byte_idx (11 bit) = 0 on the first en cycle of a frame, +1 per en cycle, saturates at 2047.
  - Cleared whenever en=0.
- Payload start:
  - At byte_idx == ETH_HDR_LEN, latch hdr_end = ETH_HDR_LEN + 4*IHL + UDP_HDR_LEN, where IHL = pcr_din[3:0].
- TS position:
  - ts_idx = (byte_idx - hdr_end) mod 188 for byte_idx >= hdr_end; meaningless before hdr_end.
- FSM, advanced only on en=1 cycles; any en=0 cycle forces IDLE:
  - IDLE: go to HDR1 when ts_idx==0 and byte==0x47.
  - HDR1 -> HDR2 -> HDR3 (unconditional).
  - HDR3: go to AFLEN if byte[5]==1, else IDLE.
  - AFLEN: go to AFFLAG if byte != 0, else IDLE.
  - AFFLAG: go to PCR0 if byte[4]==1, else IDLE.
  - PCR0..PCR4: advance one per byte.
  - PCR5 -> IDLE.
  - On the PCR0 byte, sample pcr_base_cnt and pcr_ext_cnt into holding registers.
- Rewrite, on the PCR5 byte, when all six PCR bytes sit in the delay line:
  - base_old = 33 MSBs; rsv = next 6 bits, preserved unchanged; ext_old = 9 LSBs.
  - If ext_old >= 300: field is left untouched and pcr_err_cnt increments.
  - Otherwise:
    - e = ext_old + ext_hold (10 bit).
    - If e >= 300: ext_new = e - 300, carry = 1; else ext_new = e, carry = 0.
    - base_new = (base_old + base_hold + carry) mod 2^33.
    - All 48 bits are written into the delay line in one cycle; pcr_amend_cnt increments.
- Boundaries:
  - en drops mid-PCR: FSM returns to IDLE and no partial rewrite occurs; bytes flow out unchanged.
  - Frame shorter than hdr_end: no TS parsing.
  - TS packet truncated by frame end: handled by the en drop rule.
  - A 0x47 byte at ts_idx != 0 is ignored.
  - good/bad strobes are never inspected; they are only delayed.

Decomposition:
- Shared package pcr_sfp_pkg:
  - constants ETH_HDR_LEN, UDP_HDR_LEN, TS_PKT_LEN, PCR_EXT_MOD, TS_SYNC (8'h47);
  - FSM state encoding.
- One sub-module, pcr_time_add: combinational 33+9-bit PCR adder with mod-300 extension carry, taking (base_old, ext_old, base_add, ext_add) and producing (base_new, ext_new, ext_invalid).

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-frame -> all outputs 0; first output byte appears 7 cycles after the first en following release.
- Plain TS frame (IHL=5, hdr_end=42), 7 packets, no adaptation field -> pcr_dout equals pcr_din delayed 7 cycles bit-exact; pcr_amend_cnt=0.
- PCR base=0x0_0000_1000, ext=100; inputs base_cnt=0x500, ext_cnt=50 -> output base=0x0_0000_1500, ext=150, rsv unchanged; pcr_amend_cnt=1.
- Extension carry and base wrap: PCR base=0x1_FFFF_FFFF, ext=299; base_cnt=0, ext_cnt=1 -> base=0x0_0000_0000, ext=0.
- Illegal extension: PCR ext=0x1FF -> field unchanged; pcr_err_cnt=1.
- en deasserted at the PCR2 byte, IHL=6 frame next -> no modification in the first frame; in the second frame, PCRs of TS packets at byte 46+188k are amended.
